// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN pipeline blocks.
//   DATA_W_DEF  : default signed sample width
//   gap_state_e : global-average-pooling FSM encoding (also the debug_state value)
//   clog2       : index-width helper, never returns less than 1
package cnn_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    GAP_IDLE   = 2'd0,
    GAP_ACCUM  = 2'd1,
    GAP_DIVIDE = 2'd2,
    GAP_DONE   = 2'd3
  } gap_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/gap_accum_bank.sv
// Per-channel accumulator register file for global average pooling.
//   clk, rst_n : clock, asynchronous active-low reset (clears all accumulators)
//   clr        : synchronous clear of every accumulator (wins over add_en)
//   add_en     : add sign-extended add_val into accumulator add_idx
//   add_idx    : channel being accumulated
//   add_val    : signed sample
//   rd_idx     : channel being read
//   rd_acc     : combinational read of accumulator rd_idx
module gap_accum_bank
  import cnn_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = DATA_W + 6,
  localparam int CH_W  = clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     add_en,
  input  logic [CH_W-1:0]          add_idx,
  input  logic signed [DATA_W-1:0] add_val,
  input  logic [CH_W-1:0]          rd_idx,
  output logic signed [ACC_W-1:0]  rd_acc
);

  logic signed [ACC_W-1:0] acc_q [NUM_CH];
  logic signed [ACC_W-1:0] acc_d [NUM_CH];
  logic signed [ACC_W-1:0] add_ext;

  always_comb begin
    add_ext = {{(ACC_W-DATA_W){add_val[DATA_W-1]}}, add_val};
    for (int i = 0; i < NUM_CH; i++) begin
      acc_d[i] = acc_q[i];
      if (clr) begin
        acc_d[i] = '0;
      end else if (add_en && (add_idx == CH_W'(i))) begin
        acc_d[i] = acc_q[i] + add_ext;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign rd_acc = acc_q[rd_idx];

endmodule

// File: rtl/cnn_gap_unit.sv
// Global-average-pooling stage: accumulates a channel-interleaved feature
// stream per channel, divides each sum by the map size and holds one average
// per channel for the fully connected stage.
//   clk, rst_n     : clock, asynchronous active-low reset
//   gap_en         : level enable from the control FSM
//   in_valid/in_ready/in_data : sample stream (ch0..chN-1 of pixel 0, then pixel 1, ...)
//   gap_done       : averages complete (level, held in DONE)
//   result_valid   : stored averages belong to the last completed frame
//   rd_addr/rd_data: registered read of one average, 1-cycle latency, 0 beyond NUM_CH
//   debug_state    : current FSM state encoding
//
// Handshake: a sample transfers on a rising edge where in_valid && in_ready.
// in_ready is registered and high exactly while the FSM is in ACCUM; in_data
// is ignored otherwise, and in_valid may drop at any time to stall.
module cnn_gap_unit
  import cnn_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAP_PIX  = 64,
  parameter int PIX_LG2  = 6,
  localparam int ACC_W   = DATA_W + PIX_LG2,
  localparam int CH_W    = clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     gap_en,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     gap_done,
  output logic                     result_valid,
  input  logic [CH_W-1:0]          rd_addr,
  output logic signed [DATA_W-1:0] rd_data,
  output logic [1:0]               debug_state
);

  if (MAP_PIX != (1 << PIX_LG2)) begin : g_bad_map_pix
    $error("cnn_gap_unit: MAP_PIX must equal 2**PIX_LG2");
  end
  if (NUM_CH < 2) begin : g_bad_num_ch
    $error("cnn_gap_unit: NUM_CH must be at least 2");
  end

  // Averages are stored for every encodable address; entries at or above
  // NUM_CH are never written and so read back as 0.
  localparam int AVG_DEPTH = 1 << CH_W;
  localparam logic [CH_W-1:0]    CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [PIX_LG2-1:0] PIX_LAST = PIX_LG2'(MAP_PIX - 1);

  gap_state_e state_q, state_d;
  logic [CH_W-1:0]    ch_cnt_q, ch_cnt_d;
  logic [CH_W-1:0]    div_cnt_q, div_cnt_d;
  logic [PIX_LG2-1:0] pix_cnt_q, pix_cnt_d;
  logic in_ready_q, in_ready_d;
  logic gap_done_q, gap_done_d;
  logic result_valid_q, result_valid_d;
  logic signed [DATA_W-1:0] avg_q [AVG_DEPTH];
  logic signed [DATA_W-1:0] avg_d [AVG_DEPTH];
  logic signed [DATA_W-1:0] rd_data_q, rd_data_d;

  logic                    accept;
  logic                    acc_clr;
  logic                    acc_add;
  logic signed [ACC_W-1:0] acc_rd;

  gap_accum_bank #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (acc_clr),
    .add_en  (acc_add),
    .add_idx (ch_cnt_q),
    .add_val (in_data),
    .rd_idx  (div_cnt_q),
    .rd_acc  (acc_rd)
  );

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d        = state_q;
    ch_cnt_d       = ch_cnt_q;
    pix_cnt_d      = pix_cnt_q;
    div_cnt_d      = div_cnt_q;
    result_valid_d = result_valid_q;
    avg_d          = avg_q;
    acc_clr        = 1'b0;
    acc_add        = 1'b0;

    case (state_q)
      GAP_IDLE: begin
        if (gap_en) begin
          state_d        = GAP_ACCUM;
          acc_clr        = 1'b1;
          ch_cnt_d       = '0;
          pix_cnt_d      = '0;
          div_cnt_d      = '0;
          result_valid_d = 1'b0;
        end
      end
      GAP_ACCUM: begin
        if (!gap_en) begin
          state_d        = GAP_IDLE;
          result_valid_d = 1'b0;
        end else if (accept) begin
          acc_add = 1'b1;
          if (ch_cnt_q == CH_LAST) begin
            ch_cnt_d  = '0;
            pix_cnt_d = pix_cnt_q + 1'b1;
            if (pix_cnt_q == PIX_LAST) begin
              state_d   = GAP_DIVIDE;
              div_cnt_d = '0;
            end
          end else begin
            ch_cnt_d = ch_cnt_q + 1'b1;
          end
        end
      end
      GAP_DIVIDE: begin
        if (!gap_en) begin
          state_d        = GAP_IDLE;
          result_valid_d = 1'b0;
        end else begin
          // Sum of MAP_PIX DATA_W-bit samples shifted right by PIX_LG2 always
          // lies in the DATA_W range, so plain truncation is exact.
          avg_d[div_cnt_q] = DATA_W'(acc_rd >>> PIX_LG2);
          if (div_cnt_q == CH_LAST) begin
            state_d = GAP_DONE;
          end else begin
            div_cnt_d = div_cnt_q + 1'b1;
          end
        end
      end
      GAP_DONE: begin
        // A new frame needs gap_en low for at least one cycle first.
        if (!gap_en) state_d = GAP_IDLE;
      end
      default: state_d = GAP_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    in_ready_d = (state_d == GAP_ACCUM);
    gap_done_d = (state_d == GAP_DONE);
    if (state_d == GAP_DONE) result_valid_d = 1'b1;

    rd_data_d = avg_q[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= GAP_IDLE;
      ch_cnt_q       <= '0;
      pix_cnt_q      <= '0;
      div_cnt_q      <= '0;
      in_ready_q     <= 1'b0;
      gap_done_q     <= 1'b0;
      result_valid_q <= 1'b0;
      rd_data_q      <= '0;
      for (int i = 0; i < AVG_DEPTH; i++) avg_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      ch_cnt_q       <= ch_cnt_d;
      pix_cnt_q      <= pix_cnt_d;
      div_cnt_q      <= div_cnt_d;
      in_ready_q     <= in_ready_d;
      gap_done_q     <= gap_done_d;
      result_valid_q <= result_valid_d;
      rd_data_q      <= rd_data_d;
      for (int i = 0; i < AVG_DEPTH; i++) avg_q[i] <= avg_d[i];
    end
  end

  assign in_ready     = in_ready_q;
  assign gap_done     = gap_done_q;
  assign result_valid = result_valid_q;
  assign rd_data      = rd_data_q;
  assign debug_state  = state_q;

endmodule

// File: doc/cnn_gap_unit.md
Name: cnn_gap_unit

Overview:
Global-average-pooling stage between the conv/ReLU stream and the fully connected stage. Under `gap_en` it accumulates a channel-interleaved post-ReLU feature stream per channel. After the last pixel it divides each sum by the map size, stores one average per channel and raises `gap_done` to the control FSM. The FC stage then reads the averages through a registered read port.

Parameters:
- NUM_CH, 8, number of channels (≥2).
- DATA_W, 16, signed width of input samples and stored averages.
- MAP_PIX, 64, pixels per channel map (H*W); must be a power of two.
- PIX_LG2, 6, log2(MAP_PIX); localparam-checked at elaboration.
- ACC_W, DATA_W+PIX_LG2, accumulator width (derived localparam).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- gap_en  in  1  stage enable from control FSM (level).
- in_valid  in  1  upstream sample valid.
- in_data  in  DATA_W  signed sample, channel-interleaved: ch0..ch(NUM_CH-1) of pixel 0, then pixel 1, and so on.
- in_ready  out  1  sample accepted when in_valid && in_ready.
- gap_done  out  1  averages complete (level).
- result_valid  out  1  stored averages belong to the last completed frame.
- rd_addr  in  clog2(NUM_CH)  channel index from the FC stage.
- rd_data  out  DATA_W  registered average for rd_addr.
- debug_state  out  2  current state encoding.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All accumulators, averages, counters, `rd_data` = 0.
  - `in_ready`, `gap_done`, `result_valid` = 0.
- States (IDLE=0, ACCUM=1, DIVIDE=2, DONE=3):
  - IDLE:
    - `in_ready`=0.
    - On `gap_en`=1: clear accumulators, ch_cnt and pix_cnt, clear `result_valid`, go to ACCUM next cycle.
    - The first sample can be accepted one cycle after `gap_en` rises.
  - ACCUM:
    - `in_ready`=1.
    - On each accept: acc[ch_cnt] += sign-extended in_data.
    - ch_cnt wraps NUM_CH-1→0, and pix_cnt increments on that wrap.
    - Accepting ch=NUM_CH-1 of pix=MAP_PIX-1 goes to DIVIDE; that sample is accumulated.
    - `in_valid` gaps simply stall the counters.
  - DIVIDE:
    - `in_ready`=0.
    - One channel per cycle, ch 0..NUM_CH-1: avg[ch] = acc[ch] >>> PIX_LG2 (arithmetic shift, truncation toward −inf), low DATA_W bits.
    - No saturation is needed because the result always fits in DATA_W.
    - After the NUM_CH-th write, go to DONE.
  - DONE:
    - `gap_done`=1 and `result_valid`=1.
    - Hold until `gap_en`=0, then go to IDLE.
    - `gap_done` deasserts in IDLE; averages and `result_valid` are retained.
- Latency: last sample accepted at cycle t → `gap_done` first high at t+NUM_CH+1.
- Abort: `gap_en`=0 in ACCUM or DIVIDE → IDLE next cycle, `result_valid`=0, `gap_done` never asserted.
- Reset mid-operation: immediate return to the reset state; any partial frame is discarded.
- Read port:
  - rd_data <= avg[rd_addr] every cycle, in every state (1-cycle latency).
  - rd_addr ≥ NUM_CH returns 0.
- `gap_en` rising while in DONE (no low cycle in between): no new frame starts; a low cycle is required.
- Back-to-back frames: `gap_en` low for ≥1 cycle then high restarts the sequence, clearing accumulators.

Decomposition:
- Shared package `cnn_pkg`:
  - DATA_W default.
  - GAP state encoding (used for debug decode by the top-level/debug mux).
  - clog2 function.
- Sub-module `gap_accum_bank`: the NUM_CH accumulator register file with clear, add-at-index and read-at-index ports.
- FSM and counters stay in `cnn_gap_unit`.

Test Plan (NUM_CH=4, MAP_PIX=16, DATA_W=16):
1. Constant stream, ch c = 10*(c+1), `in_valid` always 1 → `gap_done` at t+5; rd_data for rd_addr 0..3 = 10, 20, 30, 40, each one cycle after its address.
2. ch0 = pixel index 0..15, others 0 → ch0 avg = 120>>4 = 7 (truncation); others 0. Repeat with random `in_valid` gaps → identical results, and `in_ready`=0 outside ACCUM.
3. All samples 32767 → avg 32767 (no overflow). All samples −1 → avg −1 (arithmetic shift).
4. Drop `gap_en` after 30 accepted samples → IDLE next cycle, `gap_done` stays 0, `result_valid`=0. A following full frame gives correct averages with no carry-over.
5. Assert rst_n=0 asynchronously mid-DIVIDE → all outputs 0 immediately, `debug_state`=0.
6. Two consecutive frames (1-cycle `gap_en` low gap) with values 5 then 9 → averages 5, then 9; `gap_done` pulses once per frame.
